rah_tx_framer: RTL

//  Consumer of the read-request arbiter: on read_queue/app_id, drains the selected app's

---
 rtl/rah_tx_framer.sv | 91 +++++++++
 1 files changed

// File: rtl/rah_tx_framer.sv
// rah_tx_framer: drains a granted app's FWFT data queue into one framed TX burst
// (header, up to MAX_BURST payload words, trailer with word count) and pulses read_done.
module rah_tx_framer #(
  parameter int TOTAL_APPS   = 8,
  parameter int APP_ID_WIDTH = 3,
  parameter int DATA_WIDTH   = 48,
  parameter int MAX_BURST    = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             read_queue,
  input  logic [APP_ID_WIDTH-1:0]          app_id,
  output logic                             read_done,
  output logic                             busy,
  input  logic [TOTAL_APPS-1:0]            data_queue_empty,
  input  logic [TOTAL_APPS*DATA_WIDTH-1:0] data_queue_dout,
  output logic [TOTAL_APPS-1:0]            data_queue_rd_en,
  output logic [DATA_WIDTH-1:0]            tx_data,
  output logic                             tx_valid,
  output logic                             tx_last,
  input  logic                             tx_ready
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  typedef enum logic [2:0] {IDLE, HDR, DATA, TRL, DONE} state_t;
  state_t state, state_nx;
  logic [APP_ID_WIDTH-1:0] sel, sel_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] heads [TOTAL_APPS];
  logic stop;
  for (genvar i = 0; i < TOTAL_APPS; i++) begin : g_heads
    assign heads[i] = data_queue_dout[i*DATA_WIDTH +: DATA_WIDTH];
  end
  // payload ends when the selected queue runs dry or the burst cap is reached
  assign stop = data_queue_empty[sel] || cnt == CNT_W'(MAX_BURST);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      sel   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      cnt   <= cnt_nx;
    end
  always_comb begin
    state_nx         = state;
    sel_nx           = sel;
    cnt_nx           = cnt;
    read_done        = 1'b0;
    busy             = 1'b0;
    tx_valid         = 1'b0;
    tx_last          = 1'b0;
    tx_data          = '0;
    data_queue_rd_en = '0;
    case (state)
      IDLE: if (read_queue) begin
        sel_nx   = app_id;
        cnt_nx   = '0;
        state_nx = (32'(app_id) < TOTAL_APPS) ? HDR : DONE;
      end
      HDR: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = {8'hA5, 8'(sel), {(DATA_WIDTH-16){1'b0}}};
        state_nx = tx_ready ? DATA : HDR;
      end
      DATA: begin
        busy = 1'b1;
        if (stop) state_nx = TRL;
        else begin
          tx_valid         = 1'b1;
          tx_data          = heads[sel];
          data_queue_rd_en = tx_ready ? TOTAL_APPS'(1) << sel : '0;
          cnt_nx           = tx_ready ? cnt + 1'b1 : cnt;
        end
      end
      TRL: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = {8'h5A, 8'(sel), {(DATA_WIDTH-16){1'b0}}} | DATA_WIDTH'(cnt);
        state_nx = tx_ready ? DONE : TRL;
      end
      DONE: begin
        read_done = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule
